// File: rtl/move_picker.sv
`default_nettype none
// ============================================================================
// Module   : move_picker
// Brief    : Sequential best-move selector. It scans the nine tic-tac-toe
//            cells one per cycle and keeps a running maximum of the upstream
//            score over the free cells. It reports the winner as an index
//            and as a one-hot square select.
// Revision : 1.0 - initial release
// ============================================================================
module move_picker #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [8:0]   empty,
   input  logic [N-1:0] score,
   output logic [3:0]   cell_addr,
   output logic         busy,
   output logic         done,
   output logic         move_valid,
   output logic [3:0]   move_idx,
   output logic [8:0]   move_onehot,
   output logic [N-1:0] best_score
);

   localparam logic [1:0] c_ST_IDLE   = 2'd0;
   localparam logic [1:0] c_ST_SCAN   = 2'd1;
   localparam logic [1:0] c_ST_DONE   = 2'd2;
   localparam logic [3:0] c_LAST_CELL = 4'd8;

   logic [1:0]   r_state;
   logic [1:0]   w_state_nxt;

   logic [8:0]   r_mask;
   logic         r_found;
   logic [N-1:0] r_best;
   logic [3:0]   r_best_idx;

   logic         w_accept;
   logic         w_last;
   logic         w_take;
   logic         w_found_nxt;
   logic [N-1:0] w_best_nxt;
   logic [3:0]   w_idx_nxt;
   logic [8:0]   w_onehot_nxt;
   logic         w_busy_nxt;
   logic         w_done_nxt;

   // A start is only honoured when no scan is in flight.
   assign w_accept = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));

   // The final scan cycle evaluates cell 8 and produces the result.
   assign w_last = (r_state == c_ST_SCAN) && (cell_addr == c_LAST_CELL);

   // Running-maximum candidate for the current cell. The comparison is
   // strictly greater, so an equal score later in the scan never displaces
   // the earlier (lower-numbered) cell.
   always_comb begin
      w_take       = 1'b0;
      w_found_nxt  = r_found;
      w_best_nxt   = r_best;
      w_idx_nxt    = r_best_idx;
      w_onehot_nxt = 9'd0;
      if (cell_addr <= c_LAST_CELL) begin
         w_take = r_mask[cell_addr] && (!r_found || (score > r_best));
      end
      if (w_take) begin
         w_found_nxt = 1'b1;
         w_best_nxt  = score;
         w_idx_nxt   = cell_addr;
      end
      if (w_found_nxt) begin
         w_onehot_nxt = 9'd1 << w_idx_nxt;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (start) begin
               w_state_nxt = c_ST_SCAN;
            end
         end
         c_ST_SCAN: begin
            if (w_last) begin
               w_state_nxt = c_ST_DONE;
            end
         end
         c_ST_DONE: begin
            w_state_nxt = start ? c_ST_SCAN : c_ST_IDLE;
         end
         default: begin
            w_state_nxt = c_ST_IDLE;
         end
      endcase
   end

   // Output decode: next values of the registered status flags.
   always_comb begin
      w_busy_nxt = (w_state_nxt == c_ST_SCAN);
      w_done_nxt = w_last;
   end

   // Status flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= w_busy_nxt;
         done <= w_done_nxt;
      end
   end

   // Scan datapath: mask latch, address counter and running best.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mask     <= 9'd0;
         r_found    <= 1'b0;
         r_best     <= '0;
         r_best_idx <= 4'd0;
         cell_addr  <= 4'd0;
      end else if (w_accept) begin
         r_mask     <= empty;
         r_found    <= 1'b0;
         r_best     <= '0;
         r_best_idx <= 4'd0;
         cell_addr  <= 4'd0;
      end else if (r_state == c_ST_SCAN) begin
         r_found    <= w_found_nxt;
         r_best     <= w_best_nxt;
         r_best_idx <= w_idx_nxt;
         if (!w_last) begin
            cell_addr <= cell_addr + 4'd1;
         end
      end else if (r_state == c_ST_DONE) begin
         // Leaving DONE without a new start: park the address at cell 0.
         cell_addr <= 4'd0;
      end
   end

   // Result registers: cleared on an accepted start, loaded as the scan
   // finishes, and otherwise held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         move_valid  <= 1'b0;
         move_idx    <= 4'd0;
         move_onehot <= 9'd0;
         best_score  <= '0;
      end else if (w_accept) begin
         move_valid  <= 1'b0;
         move_idx    <= 4'd0;
         move_onehot <= 9'd0;
         best_score  <= '0;
      end else if (w_last) begin
         move_valid  <= w_found_nxt;
         move_idx    <= w_idx_nxt;
         move_onehot <= w_onehot_nxt;
         best_score  <= w_best_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_move_picker.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_picker
// Brief    : Scoreboard bench for move_picker. The driver issues scans and
//            queues the expected result from a reference model. A monitor
//            checks every done pulse and the held result between scans.
// Revision : 1.0 - initial release
// ============================================================================
module tb_move_picker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [8:0]  empty;
   logic [7:0]  score;
   logic [3:0]  cell_addr;
   logic        busy;
   logic        done;
   logic        move_valid;
   logic [3:0]  move_idx;
   logic [8:0]  move_onehot;
   logic [7:0]  best_score;

   logic [71:0] sc;          // cell i score at sc[8*i +: 8]
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic       v;
      logic [3:0] idx;
      logic [8:0] oh;
      logic [7:0] best;
      int         cyc;
   } exp_t;

   exp_t q[$];
   exp_t last;
   bit   have_last = 0;

   move_picker #(.N(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .empty       (empty),
      .score       (score),
      .cell_addr   (cell_addr),
      .busy        (busy),
      .done        (done),
      .move_valid  (move_valid),
      .move_idx    (move_idx),
      .move_onehot (move_onehot),
      .best_score  (best_score)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Upstream scoring logic: combinational lookup by cell address.
   assign score = (cell_addr <= 4'd8) ? sc[int'(cell_addr) * 8 +: 8] : 8'd0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [71:0] mk(int a0, int a1, int a2, int a3, int a4,
                                      int a5, int a6, int a7, int a8);
      return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
   endfunction

   // Reference: highest score among free cells; among equals, lowest index.
   function automatic exp_t model(input logic [8:0] m, input logic [71:0] s, input int dcyc);
      exp_t e;
      int   mx;
      mx    = -1;
      e.v   = 1'b0;
      e.idx = 4'd0;
      e.oh  = 9'd0;
      e.best = 8'd0;
      e.cyc = dcyc;
      for (int i = 0; i < 9; i++)
         if (m[i] && int'(s[i*8 +: 8]) > mx) mx = int'(s[i*8 +: 8]);
      for (int i = 0; i < 9; i++) begin
         if (!e.v && m[i] && int'(s[i*8 +: 8]) == mx) begin
            e.v    = 1'b1;
            e.idx  = 4'(i);
            e.best = 8'(mx);
            e.oh   = 9'd0;
            e.oh[i] = 1'b1;
         end
      end
      return e;
   endfunction

   task automatic wait_cycles(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; start is sampled at the next edge.
   task automatic launch(input logic [8:0] m, input logic [71:0] s);
      start = 1'b1;
      empty = m;
      sc    = s;
      q.push_back(model(m, s, cyc + 10));
      wait_cycles(1);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("addr_after_start", cell_addr, 0);
   endtask

   task automatic scan(input logic [8:0] m, input logic [71:0] s);
      launch(m, s);
      wait_cycles(10);
   endtask

   // Monitor: pop and compare on each done, verify held result otherwise.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            have_last = 0;
         end else if (done) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no pending scan (cycle %0d)", cyc);
            end else begin
               e = q.pop_front();
               chk("done_cycle", cyc, e.cyc);
               chk("move_valid", move_valid, e.v);
               chk("move_idx", move_idx, e.idx);
               chk("move_onehot", move_onehot, e.oh);
               chk("best_score", best_score, e.best);
               chk("busy_at_done", busy, 0);
               chk("addr_at_done", cell_addr, 8);
               last = e;
               have_last = 1;
            end
         end else if (!busy && have_last) begin
            chk("hold_valid", move_valid, last.v);
            chk("hold_idx", move_idx, last.idx);
            chk("hold_onehot", move_onehot, last.oh);
            chk("hold_best", best_score, last.best);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0]  m;
      logic [71:0] s;
      rst_n = 1'b0;
      start = 1'b0;
      empty = 9'd0;
      sc    = '0;
      #2;
      chk("rst_addr", cell_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", move_valid, 0);
      chk("rst_idx", move_idx, 0);
      chk("rst_onehot", move_onehot, 0);
      chk("rst_best", best_score, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_cycles(2);
      chk("idle_addr", cell_addr, 0);

      // Directed scans.
      scan(9'h1FF, mk(3, 7, 2, 9, 1, 0, 4, 9, 5));
      scan(9'h176, mk(10, 11, 15, 13, 14, 15, 16, 17, 200));
      scan(9'h076, mk(10, 11, 15, 13, 14, 15, 16, 17, 200));
      scan(9'h036, mk(10, 11, 15, 13, 14, 15, 16, 17, 200));
      scan(9'h000, mk(50, 60, 70, 80, 90, 1, 2, 3, 4));
      scan(9'h100, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Mid-scan start and mask change are ignored; then back-to-back.
      launch(9'h0F3, mk(5, 5, 9, 9, 6, 6, 2, 250, 8));
      wait_cycles(4);
      chk("addr_mid", cell_addr, 4);
      start = 1'b1;
      empty = 9'd0;
      wait_cycles(1);
      start = 1'b0;
      wait_cycles(4);
      launch(9'h1FF, mk(1, 2, 3, 4, 5, 6, 7, 8, 9));
      wait_cycles(10);

      // Asynchronous reset at cell 5 aborts the scan.
      launch(9'h1FF, mk(9, 9, 9, 9, 9, 9, 9, 9, 9));
      wait_cycles(5);
      chk("addr_before_rst", cell_addr, 5);
      #2 rst_n = 1'b0;
      #1;
      void'(q.pop_back());
      chk("arst_addr", cell_addr, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_valid", move_valid, 0);
      chk("arst_onehot", move_onehot, 0);
      chk("arst_best", best_score, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_cycles(1);
      scan(9'h0AA, mk(1, 40, 1, 40, 1, 41, 1, 40, 255));

      // Randomized scans with random idle gaps or back-to-back starts.
      for (int it = 0; it < 40; it++) begin
         m = 9'($urandom_range(0, 511));
         for (int i = 0; i < 9; i++)
            s[i*8 +: 8] = (it % 2 == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
         launch(m, s);
         wait_cycles(9 + (($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 3))));
      end
      wait_cycles(12);

      for (int k = 0; k < 30 && q.size() != 0; k++) wait_cycles(1);
      chk("queue_drained", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
